robo_odometria: RTL and testbench
=================================

Name: robo_odometria

Overview:
- Synthesizable position tracker sitting directly downstream of the Robo controller.
- Consumes the controller's one-cycle commands (forward, turn, remove) and maintains the robot's grid cell, orientation, move budget and event counters.
- Raises a fault on illegal motion or illegal command combinations, so map/sensor logic and the top level can read pose from hardware instead of recomputing it.

Parameters:
- ROWS, 10, number of map rows; legal linha is 1..ROWS.
- COLS, 20, number of map cells per row; legal coluna is 1..COLS.
- RW, 4, width of linha.
- CW, 5, width of coluna.
- MW, 24, width of the move budget.
- KW, 16, width of the event counters.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- init_valid  in  1  one-cycle load strobe for the start pose
- init_linha  in  RW  start row
- init_coluna  in  CW  start column (cell index)
- init_orient  in  2  start orientation: N=00, S=01, L=10, O=11
- init_moves  in  MW  move budget
- forward  in  1  controller command: advance one cell
- turn  in  1  controller command: rotate left
- remove  in  1  controller command: remove debris, pose unchanged
- linha  out  RW  current row
- coluna  out  CW  current column
- orient  out  2  current orientation
- moves_left  out  MW  remaining budget
- passos  out  KW  accepted forward count
- remocoes  out  KW  accepted remove count
- running  out  1  high in state RUN
- done  out  1  high in state DONE
- fault  out  1  high in state FAULT
- fault_code  out  2  00 none, 01 out-of-bounds forward, 10 multiple commands, 11 invalid init

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; linha=0, coluna=0, orient=00; moves_left=0; passos=0, remocoes=0; running=0, done=0, fault=0, fault_code=00.
- FSM states are IDLE, RUN, DONE, FAULT. Status outputs are registered and decoded from state.
- Init accept: init_valid is accepted in IDLE, DONE and FAULT, and ignored in RUN. On accept:
  - pose loads from init_*; moves_left=init_moves; passos=0, remocoes=0; fault_code=00.
  - If init_linha is not in 1..ROWS, or init_coluna is not in 1..COLS, the next state is FAULT with code 11 and the pose registers still load.
  - Else if init_moves=0, the next state is DONE.
  - Else the next state is RUN.
- Commands are sampled only in RUN at a rising edge. Results are visible the following cycle (latency 1). Commands are ignored in IDLE, DONE and FAULT.
- A cycle with no command is idle: nothing changes and no budget is consumed.
- More than one of forward/turn/remove high in one cycle: pose, counters and budget are unchanged; next state is FAULT with code 10.
- forward alone:
  - Target cell: N gives linha-1; S gives linha+1; L gives coluna+1; O gives coluna-1.
  - If the target is outside 1..ROWS / 1..COLS: pose unchanged, budget and passos unchanged, next state FAULT with code 01.
  - Else the pose moves to the target and passos increments.
- turn alone: N→O, O→S, S→L, L→N. Position is unchanged.
- remove alone: pose unchanged; remocoes increments.
- Every accepted legal command decrements moves_left by 1. When the decrement reaches 0, the next state is DONE in the same edge as the final update.
- passos and remocoes saturate at 2^KW-1 and never wrap.
- moves_left never underflows; no decrement is possible outside RUN.
- Reset asserted mid-RUN aborts immediately to the reset values above; a new init is required.

Test Plan:
- Reset, then init (1,4,S,25) → next cycle running=1, linha=1, coluna=4, orient=01, moves_left=25.
- From (1,4,S,25): forward ×3 → linha=4, passos=3, moves_left=22. Then turn → orient=10 (L). Then forward → coluna=5, moves_left=20.
- Init (1,4,N,5), then forward → fault=1, fault_code=01, linha=1, moves_left=5. Then init (2,2,O,2) from FAULT → running=1, fault_code=00.
- Init (3,3,N,10), then forward+turn in the same cycle → fault_code=10, pose (3,3,N), moves_left=10.
- Init (5,5,N,2), then remove, then turn → remocoes=1, orient=11, moves_left=0, done=1. A further forward is ignored: linha stays 5.
- Init (0,4,N,3) → fault_code=11. Init (2,2,N,0) → done=1. Assert reset mid-RUN → all outputs return to 0 within the same cycle.

Source files
------------

// File: rtl/robo_odometria.sv
// Pose tracker for the Robo controller: folds one-cycle forward/turn/remove commands into
// grid position, heading, remaining move budget and saturating event counters.
module robo_odometria #(
  parameter int unsigned ROWS = 10,
  parameter int unsigned COLS = 20,
  parameter int unsigned RW   = 4,
  parameter int unsigned CW   = 5,
  parameter int unsigned MW   = 24,
  parameter int unsigned KW   = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          init_valid,
  input  logic [RW-1:0] init_linha,
  input  logic [CW-1:0] init_coluna,
  input  logic [1:0]    init_orient,
  input  logic [MW-1:0] init_moves,
  input  logic          forward,
  input  logic          turn,
  input  logic          remove,
  output logic [RW-1:0] linha,
  output logic [CW-1:0] coluna,
  output logic [1:0]    orient,
  output logic [MW-1:0] moves_left,
  output logic [KW-1:0] passos,
  output logic [KW-1:0] remocoes,
  output logic          running,
  output logic          done,
  output logic          fault,
  output logic [1:0]    fault_code
);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StFault} state_t;

  localparam logic [1:0] OriN = 2'b00;
  localparam logic [1:0] OriS = 2'b01;
  localparam logic [1:0] OriL = 2'b10;
  localparam logic [1:0] OriO = 2'b11;

  localparam logic [1:0] CodeNone   = 2'b00;
  localparam logic [1:0] CodeBounds = 2'b01;
  localparam logic [1:0] CodeMulti  = 2'b10;
  localparam logic [1:0] CodeInit   = 2'b11;

  state_t        state, state_d;
  logic [RW-1:0] linha_d;
  logic [CW-1:0] coluna_d;
  logic [1:0]    orient_d;
  logic [MW-1:0] moves_d;
  logic [KW-1:0] passos_d;
  logic [KW-1:0] remocoes_d;
  logic [1:0]    code_d;

  // One extra bit so that a step off either edge (0 or ROWS+1) stays representable.
  logic [RW:0]   tgt_lin;
  logic [CW:0]   tgt_col;
  logic          tgt_ok;
  logic          init_ok;
  logic [1:0]    cmd_cnt;
  logic          legal;
  logic [1:0]    turned;

  always_comb begin
    tgt_lin = {1'b0, linha};
    tgt_col = {1'b0, coluna};
    unique case (orient)
      OriN: tgt_lin = {1'b0, linha} - (RW + 1)'(1);
      OriS: tgt_lin = {1'b0, linha} + (RW + 1)'(1);
      OriL: tgt_col = {1'b0, coluna} + (CW + 1)'(1);
      OriO: tgt_col = {1'b0, coluna} - (CW + 1)'(1);
      default: ;
    endcase
  end

  assign tgt_ok = (tgt_lin != '0) && (tgt_lin <= ROWS[RW:0]) &&
                  (tgt_col != '0) && (tgt_col <= COLS[CW:0]);

  assign init_ok = (init_linha != '0) && ({1'b0, init_linha} <= ROWS[RW:0]) &&
                   (init_coluna != '0) && ({1'b0, init_coluna} <= COLS[CW:0]);

  assign cmd_cnt = 2'(forward) + 2'(turn) + 2'(remove);

  // Left rotation: N -> O -> S -> L -> N.
  always_comb begin
    turned = OriN;
    unique case (orient)
      OriN: turned = OriO;
      OriO: turned = OriS;
      OriS: turned = OriL;
      OriL: turned = OriN;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state;
    linha_d    = linha;
    coluna_d   = coluna;
    orient_d   = orient;
    moves_d    = moves_left;
    passos_d   = passos;
    remocoes_d = remocoes;
    code_d     = fault_code;
    legal      = 1'b0;

    unique case (state)
      StRun: begin
        if (cmd_cnt > 2'd1) begin
          state_d = StFault;
          code_d  = CodeMulti;
        end else if (cmd_cnt == 2'd1) begin
          legal = 1'b1;
          if (forward) begin
            if (tgt_ok) begin
              linha_d  = tgt_lin[RW-1:0];
              coluna_d = tgt_col[CW-1:0];
              if (passos != '1) passos_d = passos + KW'(1);
            end else begin
              legal   = 1'b0;
              state_d = StFault;
              code_d  = CodeBounds;
            end
          end
          if (turn) orient_d = turned;
          if (remove && (remocoes != '1)) remocoes_d = remocoes + KW'(1);
          if (legal && (moves_left != '0)) begin
            moves_d = moves_left - MW'(1);
            if (moves_left == MW'(1)) state_d = StDone;
          end
        end
      end
      default: begin
        if (init_valid) begin
          linha_d    = init_linha;
          coluna_d   = init_coluna;
          orient_d   = init_orient;
          moves_d    = init_moves;
          passos_d   = '0;
          remocoes_d = '0;
          code_d     = CodeNone;
          if (!init_ok) begin
            state_d = StFault;
            code_d  = CodeInit;
          end else if (init_moves == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      linha      <= '0;
      coluna     <= '0;
      orient     <= OriN;
      moves_left <= '0;
      passos     <= '0;
      remocoes   <= '0;
      fault_code <= CodeNone;
      running    <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      linha      <= linha_d;
      coluna     <= coluna_d;
      orient     <= orient_d;
      moves_left <= moves_d;
      passos     <= passos_d;
      remocoes   <= remocoes_d;
      fault_code <= code_d;
      running    <= (state_d == StRun);
      done       <= (state_d == StDone);
      fault      <= (state_d == StFault);
    end
  end

endmodule

// File: tb/tb_robo_odometria.sv
// Randomised and directed bench for robo_odometria: a pose/budget reference model feeds a
// scoreboard queue that a free-running monitor drains one entry per clock.
module tb_robo_odometria;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_valid = 1'b0;
  logic [3:0]  init_linha = '0;
  logic [4:0]  init_coluna = '0;
  logic [1:0]  init_orient = '0;
  logic [23:0] init_moves = '0;
  logic        forward = 1'b0, turn = 1'b0, remove = 1'b0;
  logic [3:0]  linha;
  logic [4:0]  coluna;
  logic [1:0]  orient;
  logic [23:0] moves_left;
  logic [15:0] passos, remocoes;
  logic        running, done, fault;
  logic [1:0]  fault_code;

  robo_odometria dut (
    .clock(clock), .reset(reset), .init_valid(init_valid), .init_linha(init_linha),
    .init_coluna(init_coluna), .init_orient(init_orient), .init_moves(init_moves),
    .forward(forward), .turn(turn), .remove(remove), .linha(linha), .coluna(coluna),
    .orient(orient), .moves_left(moves_left), .passos(passos), .remocoes(remocoes),
    .running(running), .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  lin;
    logic [4:0]  col;
    logic [1:0]  ori;
    logic [23:0] mv;
    logic [15:0] pas;
    logic [15:0] rem;
    logic        run;
    logic        dn;
    logic        flt;
    logic [1:0]  code;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 done, 3 fault. Headings N=0 S=1 L=2 O=3.
  int m_mode, m_row, m_col, m_dir, m_mv, m_pas, m_rem, m_code;
  int d_row[4] = '{-1, 1, 0, 0};
  int d_col[4] = '{0, 0, 1, -1};
  int left_of[4] = '{3, 2, 0, 1};

  function automatic void model_reset();
    m_mode = 0; m_row = 0; m_col = 0; m_dir = 0;
    m_mv = 0; m_pas = 0; m_rem = 0; m_code = 0;
  endfunction

  function automatic void model_step(input int iv, input int il, input int ic, input int io,
                                     input int im, input int f, input int t, input int r);
    int nr, nc;
    if (m_mode == 1) begin
      if (f + t + r > 1) begin
        m_mode = 3; m_code = 2;
      end else if (f + t + r == 1) begin
        if (f == 1) begin
          nr = m_row + d_row[m_dir];
          nc = m_col + d_col[m_dir];
          if (nr < 1 || nr > 10 || nc < 1 || nc > 20) begin
            m_mode = 3; m_code = 1;
            return;
          end
          m_row = nr; m_col = nc;
          if (m_pas < 65535) m_pas++;
        end
        if (t == 1) m_dir = left_of[m_dir];
        if (r == 1 && m_rem < 65535) m_rem++;
        m_mv--;
        if (m_mv == 0) m_mode = 2;
      end
    end else if (iv == 1) begin
      m_row = il; m_col = ic; m_dir = io; m_mv = im;
      m_pas = 0; m_rem = 0; m_code = 0;
      if (il < 1 || il > 10 || ic < 1 || ic > 20) begin
        m_mode = 3; m_code = 3;
      end else if (im == 0) m_mode = 2;
      else m_mode = 1;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.lin = 4'(m_row); o.col = 5'(m_col); o.ori = 2'(m_dir); o.mv = 24'(m_mv);
    o.pas = 16'(m_pas); o.rem = 16'(m_rem);
    o.run = (m_mode == 1); o.dn = (m_mode == 2); o.flt = (m_mode == 3);
    o.code = 2'(m_code);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.lin = linha; o.col = coluna; o.ori = orient; o.mv = moves_left;
    o.pas = passos; o.rem = remocoes; o.run = running; o.dn = done; o.flt = fault;
    o.code = fault_code;
    return o;
  endfunction

  function automatic void compare(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got pos=(%0d,%0d) ori=%0d mv=%0d pas=%0d rem=%0d r/d/f=%b%b%b code=%0d want pos=(%0d,%0d) ori=%0d mv=%0d pas=%0d rem=%0d r/d/f=%b%b%b code=%0d",
               name, got.lin, got.col, got.ori, got.mv, got.pas, got.rem, got.run, got.dn,
               got.flt, got.code, exp.lin, exp.col, exp.ori, exp.mv, exp.pas, exp.rem,
               exp.run, exp.dn, exp.flt, exp.code);
    end
  endfunction

  // Monitor: one registered response per driven cycle, visible just after the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) compare("cycle", dut_obs(), sb.pop_front());
    end
  end

  task automatic drive(input int iv, input int il, input int ic, input int io, input int im,
                       input int f, input int t, input int r);
    @(negedge clock);
    init_valid  = iv[0];
    init_linha  = il[3:0];
    init_coluna = ic[4:0];
    init_orient = io[1:0];
    init_moves  = im[23:0];
    forward = f[0]; turn = t[0]; remove = r[0];
    model_step(iv, il, ic, io, im, f, t, r);
    sb.push_back(model_obs());
  endtask

  task automatic init(input int il, input int ic, input int io, input int im);
    drive(1, il, ic, io, im, 0, 0, 0);
  endtask

  task automatic cmd(input int f, input int t, input int r);
    drive(0, 0, 0, 0, 0, f, t, r);
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clock);
    init_valid = 1'b0; forward = 1'b0; turn = 1'b0; remove = 1'b0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clock);
      #2;
      guard++;
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain got %0d pending entries want 0", sb.size());
      sb.delete();
    end
  endtask

  // Asynchronous reset between edges must clear every output at once.
  task automatic async_reset(input string name);
    obs_t zero;
    drain();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    zero = '0;
    compare(name, dut_obs(), zero);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    obs_t zero;
    int iv, il, ic, io, im, f, t, r, sel;
    model_reset();
    zero = '0;
    #12;
    compare("reset_state", dut_obs(), zero);
    @(negedge clock);
    reset = 1'b0;

    init(1, 4, 1, 25);
    repeat (3) cmd(1, 0, 0);
    cmd(0, 0, 0);
    cmd(0, 1, 0);
    cmd(1, 0, 0);
    async_reset("reset_mid_run");

    init(1, 4, 0, 5);
    cmd(1, 0, 0);
    init(2, 2, 3, 2);
    cmd(1, 1, 0);
    init(3, 3, 0, 10);
    cmd(1, 1, 0);
    init(5, 5, 0, 2);
    cmd(0, 0, 1);
    cmd(0, 1, 0);
    cmd(1, 0, 0);
    init(0, 4, 0, 3);
    init(2, 21, 0, 3);
    init(2, 2, 0, 0);
    init(10, 20, 1, 4);
    cmd(1, 0, 0);
    cmd(0, 1, 1);
    init(10, 20, 2, 4);
    cmd(1, 0, 0);

    // Counter saturation: more removes than the 16-bit counter can hold.
    init(5, 5, 0, 70000);
    repeat (65537) cmd(0, 0, 1);
    cmd(1, 0, 0);
    cmd(0, 1, 1);
    async_reset("reset_after_sat");

    for (int i = 0; i < 3000; i++) begin
      iv = 0; il = 0; ic = 0; io = 0; im = 0; f = 0; t = 0; r = 0;
      if (m_mode != 1 || $urandom_range(0, 39) == 0) begin
        iv = 1;
        if ($urandom_range(0, 99) < 85) begin
          il = $urandom_range(1, 10); ic = $urandom_range(1, 20);
        end else begin
          il = $urandom_range(0, 15); ic = $urandom_range(0, 31);
        end
        io = $urandom_range(0, 3);
        im = $urandom_range(0, 25);
      end
      sel = $urandom_range(0, 99);
      if (sel < 50) f = 1;
      else if (sel < 70) t = 1;
      else if (sel < 88) r = 1;
      else if (sel < 95) begin
        f = $urandom_range(0, 1); t = 1; r = (f == 1) ? $urandom_range(0, 1) : 1;
      end
      drive(iv, il, ic, io, im, f, t, r);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
